// File: rtl/bcd_timer_pkg.sv
// Shared types, digit limits and load validation for the BCD countdown timer.
// Exports timer_state_t, bcd_t, digit maxima and bcd_time_valid().
package bcd_timer_pkg;

  typedef logic [3:0] bcd_t;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSED,
    DONE
  } timer_state_t;

  localparam bcd_t BCD_MAX_LSB      = 4'd9;
  localparam bcd_t BCD_MAX_MSB      = 4'd5;
  localparam bcd_t HR_MAX_MSB       = 4'd2;
  localparam bcd_t HR_MAX_LSB_AT_2  = 4'd3;

  function automatic logic bcd_time_valid(
    input bcd_t sl,
    input bcd_t sm,
    input bcd_t ml,
    input bcd_t mm,
    input bcd_t hl,
    input bcd_t hm
  );
    logic ok;
    ok = (sl <= BCD_MAX_LSB) && (sm <= BCD_MAX_MSB)
      && (ml <= BCD_MAX_LSB) && (mm <= BCD_MAX_MSB)
      && (hl <= BCD_MAX_LSB) && (hm <= HR_MAX_MSB);
    if (hm == HR_MAX_MSB && hl > HR_MAX_LSB_AT_2)
      ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/bcd_countdown_timer_digit.sv
// One BCD digit of the down-counting borrow chain.
// Ports: digit, max, borrow_in -> digit_next, borrow_out.
module bcd_digit_down (
  input  logic [3:0] digit,
  input  logic [3:0] max,
  input  logic       borrow_in,
  output logic [3:0] digit_next,
  output logic       borrow_out
);

  logic zero;

  assign zero       = (digit == 4'd0);
  assign borrow_out = borrow_in & zero;
  assign digit_next = !borrow_in ? digit
                    : zero       ? max
                    :              digit - 4'd1;

endmodule

// File: rtl/bcd_countdown_timer.sv
// HH:MM:SS BCD countdown timer with load/start/stop and expiry pulse.
// Ports: clk, rst_n, load, start, stop, *_in digits -> *_out digits,
// running, done, expired, load_err. Optional AUTO_RELOAD_EN makes it
// reload the last accepted load value on expiry and keep running.
module bcd_countdown_timer #(
  parameter int TICK_DIV = 1,
  parameter int CW       = 16
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       load,
  input  logic       start,
  input  logic       stop,
  input  logic [3:0] sec_in_lsb,
  input  logic [3:0] sec_in_msb,
  input  logic [3:0] min_in_lsb,
  input  logic [3:0] min_in_msb,
  input  logic [3:0] hr_in_lsb,
  input  logic [3:0] hr_in_msb,
  output logic [3:0] sec_out_lsb,
  output logic [3:0] sec_out_msb,
  output logic [3:0] min_out_lsb,
  output logic [3:0] min_out_msb,
  output logic [3:0] hr_out_lsb,
  output logic [3:0] hr_out_msb,
  output logic       running,
  output logic       done,
  output logic       expired,
  output logic       load_err
);

  import bcd_timer_pkg::*;

  localparam logic [CW-1:0] PRESC_TOP = CW'(TICK_DIV - 1);
  localparam logic [5:0][3:0] DIG_MAX = {
    HR_MAX_MSB, BCD_MAX_LSB, BCD_MAX_MSB,
    BCD_MAX_LSB, BCD_MAX_MSB, BCD_MAX_LSB
  };

  timer_state_t    state, state_n;
  logic [5:0][3:0] cnt, cnt_n, dec, din;
  logic [CW-1:0]   presc, presc_n;
  logic [6:0]      brw;
  logic            exp_n, err_n;
  logic            valid, tick, cnt_zero, dec_zero;

  assign din = {hr_in_msb, hr_in_lsb, min_in_msb,
                min_in_lsb, sec_in_msb, sec_in_lsb};

  assign brw[0] = 1'b1;

  for (genvar i = 0; i < 6; i++) begin : g_dig
    bcd_digit_down u_dig (
      .digit      (cnt[i]),
      .max        (DIG_MAX[i]),
      .borrow_in  (brw[i]),
      .digit_next (dec[i]),
      .borrow_out (brw[i+1])
    );
  end

  // A borrow escaping the top digit means the count is already zero.
  assign cnt_zero = brw[6];
  assign dec_zero = (dec == '0);
  assign tick     = (presc == PRESC_TOP);
  assign valid    = bcd_time_valid(sec_in_lsb, sec_in_msb,
                                   min_in_lsb, min_in_msb,
                                   hr_in_lsb, hr_in_msb);

`ifdef AUTO_RELOAD_EN
  logic [5:0][3:0] rld, rld_n;
`endif

  always_comb begin
    state_n = state;
    cnt_n   = cnt;
    presc_n = presc;
    exp_n   = 1'b0;
    err_n   = 1'b0;
`ifdef AUTO_RELOAD_EN
    rld_n   = rld;
`endif
    if (load) begin
      if (valid) begin
        cnt_n   = din;
        state_n = IDLE;
        presc_n = '0;
`ifdef AUTO_RELOAD_EN
        rld_n   = din;
`endif
      end else begin
        err_n = 1'b1;
      end
    end else if (stop) begin
      if (state == RUN)
        state_n = PAUSED;
    end else if (start && state == IDLE) begin
      if (cnt_zero) begin
        state_n = DONE;
        exp_n   = 1'b1;
      end else begin
        state_n = RUN;
      end
    end else if (start && state == PAUSED) begin
      state_n = RUN;
    end else if (state == RUN) begin
      if (tick) begin
        presc_n = '0;
        cnt_n   = dec;
        if (dec_zero) begin
          exp_n = 1'b1;
`ifdef AUTO_RELOAD_EN
          if (rld != '0)
            cnt_n = rld;
          else
            state_n = DONE;
`else
          state_n = DONE;
`endif
        end
      end else begin
        presc_n = presc + 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state    <= IDLE;
      cnt      <= '0;
      presc    <= '0;
      expired  <= 1'b0;
      load_err <= 1'b0;
`ifdef AUTO_RELOAD_EN
      rld      <= '0;
`endif
    end else begin
      state    <= state_n;
      cnt      <= cnt_n;
      presc    <= presc_n;
      expired  <= exp_n;
      load_err <= err_n;
`ifdef AUTO_RELOAD_EN
      rld      <= rld_n;
`endif
    end
  end

  assign sec_out_lsb = cnt[0];
  assign sec_out_msb = cnt[1];
  assign min_out_lsb = cnt[2];
  assign min_out_msb = cnt[3];
  assign hr_out_lsb  = cnt[4];
  assign hr_out_msb  = cnt[5];
  assign running     = (state == RUN);
  assign done        = (state == DONE);

endmodule
